// File: rtl/cos_packet_transmit_pkg.sv
// Shared definitions for the chain packet transmitters: packet type codes,
// header field positions and the transmit FSM state encoding.
package cos_packet_transmit_pkg;

  // Packet type codes carried in the top nibble of every header word.
  localparam logic [3:0] PktLog  = 4'h1;
  localparam logic [3:0] PktCos  = 4'h2;
  localparam logic [3:0] PktMon  = 4'h3;
  localparam logic [3:0] PktTime = 4'h4;
  localparam logic [3:0] PktPing = 4'h5;

  // Header word layout.
  localparam int unsigned HdrTypeMsb = 15;
  localparam int unsigned HdrTypeLsb = 12;
  localparam int unsigned HdrNodeMsb = 11;
  localparam int unsigned HdrNodeLsb = 8;
  localparam int unsigned HdrSeqMsb  = 7;
  localparam int unsigned HdrSeqLsb  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StData
  } tx_state_e;

  function automatic logic [15:0] build_header(input logic [3:0] pkt_type,
                                               input logic [3:0] node,
                                               input logic [7:0] seq);
    logic [15:0] hdr;
    hdr = '0;
    hdr[HdrTypeMsb:HdrTypeLsb] = pkt_type;
    hdr[HdrNodeMsb:HdrNodeLsb] = node;
    hdr[HdrSeqMsb:HdrSeqLsb]   = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/cos_packet_transmit_heartbeat_timer.sv
// Saturating idle-cycle counter; flags when an unchanged vector is due to be resent.
module cos_heartbeat_timer #(
  parameter int unsigned HEARTBEAT_CYCLES = 1250000
) (
  input  logic clk,
  input  logic reset,
  input  logic count,
  input  logic clear,
  output logic due
);

  localparam int unsigned CntW = $clog2(HEARTBEAT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(HEARTBEAT_CYCLES - 1);

  logic [CntW-1:0] count_q;

  assign due = (count_q == CntMax);

  // Clear wins over counting; counting stops at the due value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count && !due) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/cos_packet_transmit.sv
// Sends a header plus the snapshotted interlock vector over AXI-Stream whenever the
// vector changes, after reset, or when the heartbeat interval elapses unchanged.
module cos_packet_transmit
  import cos_packet_transmit_pkg::*;
#(
  parameter int unsigned AXI_WIDTH           = 16,
  parameter int unsigned INTERLOCKS_PER_NODE = 64,
  parameter int unsigned NODE_INDEX          = 0,
  parameter logic [3:0]  COS_PACKET_TYPE     = PktCos,
  parameter int unsigned HEARTBEAT_CYCLES    = 1250000,
  parameter string       DEBUG               = "false"
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [INTERLOCKS_PER_NODE-1:0] interlockState,
  (* mark_debug = DEBUG *)
  output logic [AXI_WIDTH-1:0]           outgoingTDATA,
  (* mark_debug = DEBUG *)
  output logic                           outgoingTVALID,
  (* mark_debug = DEBUG *)
  output logic                           outgoingTLAST,
  (* mark_debug = DEBUG *)
  input  logic                           outgoingTREADY,
  output logic [15:0]                    packetsSent,
  output logic                           heartbeatSent
);

  localparam int unsigned Words = INTERLOCKS_PER_NODE / AXI_WIDTH;
  localparam int unsigned IdxW  = $clog2(Words + 1);

  if (AXI_WIDTH != 16) begin : g_bad_axi_width
    $error("AXI_WIDTH must be 16");
  end
  if ((INTERLOCKS_PER_NODE % AXI_WIDTH) != 0 || INTERLOCKS_PER_NODE == 0) begin : g_bad_vec
    $error("INTERLOCKS_PER_NODE must be a non-zero multiple of AXI_WIDTH");
  end
  if (HEARTBEAT_CYCLES < 2) begin : g_bad_hb
    $error("HEARTBEAT_CYCLES must be at least 2");
  end
  if (DEBUG != "false" && DEBUG != "true") begin : g_bad_debug
    $error("DEBUG must be \"true\" or \"false\"");
  end

  tx_state_e                    state_q, state_d;
  logic [INTERLOCKS_PER_NODE-1:0] snapshot_q;
  logic [INTERLOCKS_PER_NODE-1:0] last_sent_q;
  logic                         force_q;
  logic                         hb_only_q;
  logic [7:0]                   seq_q;
  logic [IdxW-1:0]              word_idx_q;
  logic [15:0]                  pkts_q;
  logic                         hb_pulse_q;

  logic hb_due;
  logic changed;
  logic trigger;
  logic start;
  logic hs;
  logic last_word;
  logic done;
  logic [INTERLOCKS_PER_NODE-1:0] shifted;

  assign changed   = (interlockState != last_sent_q);
  assign trigger   = force_q | changed | hb_due;
  assign start     = (state_q == StIdle) & trigger;
  assign hs        = outgoingTVALID & outgoingTREADY;
  assign last_word = (word_idx_q == IdxW'(Words));
  assign done      = (state_q == StData) & hs & last_word;

  cos_heartbeat_timer #(
    .HEARTBEAT_CYCLES(HEARTBEAT_CYCLES)
  ) u_heartbeat_timer (
    .clk  (clk),
    .reset(reset),
    .count(state_q == StIdle),
    .clear(start),
    .due  (hb_due)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: leave IDLE on trigger, advance only on handshakes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (trigger) state_d = StHeader;
      StHeader: if (hs) state_d = StData;
      StData:   if (hs && last_word) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Snapshot, word index, sequence and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      snapshot_q  <= '0;
      last_sent_q <= '0;
      force_q     <= 1'b1;
      hb_only_q   <= 1'b0;
      seq_q       <= '0;
      word_idx_q  <= '0;
      pkts_q      <= '0;
      hb_pulse_q  <= 1'b0;
    end else begin
      hb_pulse_q <= done & hb_only_q;
      if (start) begin
        snapshot_q  <= interlockState;
        last_sent_q <= interlockState;
        force_q     <= 1'b0;
        hb_only_q   <= ~force_q & ~changed;
      end
      if (state_q == StHeader && hs) begin
        word_idx_q <= IdxW'(1);
      end else if (state_q == StData && hs && !last_word) begin
        word_idx_q <= word_idx_q + 1'b1;
      end
      if (done) begin
        pkts_q <= pkts_q + 16'd1;
        seq_q  <= seq_q + 8'd1;
      end
    end
  end

  // Word k sits at the top of the snapshot after shifting out k-1 earlier words.
  always_comb begin
    shifted = snapshot_q << (AXI_WIDTH * (32'(word_idx_q) - 32'd1));
  end

  // Stream outputs decoded from state; they only move on a handshake or a start.
  always_comb begin
    outgoingTVALID = (state_q != StIdle);
    outgoingTLAST  = (state_q == StData) && last_word;
    outgoingTDATA  = '0;
    unique case (state_q)
      StHeader: outgoingTDATA = build_header(COS_PACKET_TYPE, 4'(NODE_INDEX), seq_q);
      StData:   outgoingTDATA = shifted[INTERLOCKS_PER_NODE-1 -: AXI_WIDTH];
      default:  outgoingTDATA = '0;
    endcase
  end

  assign packetsSent   = pkts_q;
  assign heartbeatSent = hb_pulse_q;

endmodule

// File: tb/tb_cos_packet_transmit.sv
// Bench for cos_packet_transmit: a cycle table for the first packet, directed corner
// sequences, and randomized traffic checked against a packet-queue reference model.
module tb_cos_packet_transmit;

  localparam int unsigned Ipn  = 64;
  localparam int unsigned Aw   = 16;
  localparam int unsigned W    = Ipn / Aw;
  localparam int unsigned Node = 5;
  localparam int unsigned Hb   = 100;

  logic            clk = 1'b0;
  logic            reset;
  logic [Ipn-1:0]  interlockState;
  logic [Aw-1:0]   outgoingTDATA;
  logic            outgoingTVALID;
  logic            outgoingTLAST;
  logic            outgoingTREADY;
  logic [15:0]     packetsSent;
  logic            heartbeatSent;

  int vectors    = 0;
  int miscompares = 0;
  bit rand_rdy   = 1'b0;

  always #5 clk = ~clk;

  cos_packet_transmit #(
    .NODE_INDEX      (Node),
    .HEARTBEAT_CYCLES(Hb)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .interlockState(interlockState),
    .outgoingTDATA (outgoingTDATA),
    .outgoingTVALID(outgoingTVALID),
    .outgoingTLAST (outgoingTLAST),
    .outgoingTREADY(outgoingTREADY),
    .packetsSent   (packetsSent),
    .heartbeatSent (heartbeatSent)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [Ipn-1:0] v, input int k);
    return v[Ipn-1-Aw*(k-1) -: Aw];
  endfunction

  // Reference model: a packet is a queue of words; the stream shows its head.
  bit             m_busy, m_force, m_hb_only, m_pulse;
  logic [Ipn-1:0] m_last;
  int             m_seq, m_pkts, m_idle;
  logic [15:0]    m_q[$];
  logic [15:0]    m_head;

  always @(posedge clk) begin
    logic           r, t;
    logic [Ipn-1:0] v;
    r = reset;
    v = interlockState;
    t = outgoingTREADY;
    m_pulse = 1'b0;
    if (r) begin
      m_busy = 1'b0; m_force = 1'b1; m_last = '0; m_seq = 0; m_pkts = 0; m_idle = 0;
      m_hb_only = 1'b0;
      m_q.delete();
    end else if (!m_busy) begin
      if (m_force || v != m_last || m_idle == Hb - 1) begin
        m_hb_only = !m_force && (v == m_last);
        m_q.delete();
        m_q.push_back({4'h2, 4'(Node), 8'(m_seq)});
        for (int k = 1; k <= W; k++) m_q.push_back(word_of(v, k));
        m_busy = 1'b1; m_force = 1'b0; m_last = v; m_idle = 0;
      end else if (m_idle < Hb - 1) begin
        m_idle++;
      end
    end else if (t) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_busy  = 1'b0;
        m_pkts  = (m_pkts + 1) % 65536;
        m_seq   = (m_seq + 1) % 256;
        m_pulse = m_hb_only;
      end
    end
    m_head = 16'h0;
    if (m_busy) m_head = m_q[0];
    #1;
    check("mdl_tvalid", outgoingTVALID, m_busy);
    check("mdl_tdata", outgoingTDATA, m_head);
    check("mdl_tlast", outgoingTLAST, m_busy && m_q.size() == 1);
    check("mdl_packets", packetsSent, m_pkts);
    check("mdl_heartbeat", heartbeatSent, m_pulse);
  end

  task automatic tick();
    @(negedge clk);
    if (rand_rdy) outgoingTREADY = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_pkts(input int target, input int budget, input string name);
    int n = 0;
    while (packetsSent != 16'(target) && n < budget) begin
      tick();
      n++;
    end
    check(name, packetsSent, 16'(target));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!outgoingTVALID && n < 200) begin
      tick();
      n++;
    end
    check(name, outgoingTVALID, 1'b1);
  endtask

  typedef struct {
    bit             rst;
    logic [Ipn-1:0] vec;
    bit             rdy;
    bit             ev;
    logic [15:0]    ed;
    bit             el;
    logic [15:0]    ep;
  } row_t;

  row_t tbl[9];

  initial begin
    int             n;
    int             pulses;
    logic [Ipn-1:0] v0;
    logic [Ipn-1:0] pool[4];

    v0 = 64'h0123_4567_89AB_CDEF;
    reset = 1'b1;
    interlockState = v0;
    outgoingTREADY = 1'b1;

    tbl[0] = '{1'b1, v0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[1] = '{1'b1, v0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[2] = '{1'b0, v0, 1'b1, 1'b1, 16'h2500, 1'b0, 16'd0};
    tbl[3] = '{1'b0, v0, 1'b1, 1'b1, 16'h0123, 1'b0, 16'd0};
    tbl[4] = '{1'b0, v0, 1'b1, 1'b1, 16'h4567, 1'b0, 16'd0};
    tbl[5] = '{1'b0, v0, 1'b1, 1'b1, 16'h89AB, 1'b0, 16'd0};
    tbl[6] = '{1'b0, v0, 1'b1, 1'b1, 16'hCDEF, 1'b1, 16'd0};
    tbl[7] = '{1'b0, v0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd1};
    tbl[8] = '{1'b0, v0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd1};

    // First packet straight out of reset.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      reset          = tbl[i].rst;
      interlockState = tbl[i].vec;
      outgoingTREADY = tbl[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_valid", i), outgoingTVALID, tbl[i].ev);
      check($sformatf("tbl%0d_data", i), outgoingTDATA, tbl[i].ed);
      check($sformatf("tbl%0d_last", i), outgoingTLAST, tbl[i].el);
      check($sformatf("tbl%0d_pkts", i), packetsSent, tbl[i].ep);
    end

    // Heartbeat: last handshake was on row 7's edge, row 8 is the first idle edge.
    n = 1;
    while (!outgoingTVALID && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hb_gap", n, Hb);
    check("hb_header", outgoingTDATA, 16'h2501);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (heartbeatSent) pulses++;
    end
    check("hb_pulse_count", pulses, 1);

    // Random backpressure with a change to all-ones mid-packet.
    rand_rdy = 1'b1;
    tick();
    interlockState = 64'hA5A5_0000_1234_5678;
    wait_valid("chg_start");
    tick();
    tick();
    interlockState = '1;
    wait_pkts(4, 400, "chg_pkts");

    // 0 -> 1 -> 0 transient inside a stalled packet is not reported.
    rand_rdy = 1'b0;
    outgoingTREADY = 1'b0;
    tick();
    interlockState = '0;
    wait_valid("rev_start");
    tick();
    tick();
    interlockState = 64'h1;
    tick();
    tick();
    interlockState = '0;
    tick();
    outgoingTREADY = 1'b1;
    wait_pkts(5, 50, "rev_pkts");
    repeat (30) tick();
    check("rev_no_extra", packetsSent, 16'd5);

    // 256 changes from reset: sequence wraps through 0xFF back to 0x00.
    reset = 1'b1;
    interlockState = 64'h1;
    tick();
    tick();
    reset = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) interlockState = interlockState + 64'd1;
      wait_pkts(i + 1, 200, "seq_pkts");
    end
    check("seq_total", packetsSent, 16'd256);
    interlockState = interlockState + 64'd1;
    wait_valid("seq_wrap_start");
    check("seq_wrap_header", outgoingTDATA, 16'h2500);
    wait_pkts(257, 200, "seq_wrap_pkts");

    // Reset while presenting data word 2.
    rand_rdy = 1'b0;
    outgoingTREADY = 1'b0;
    tick();
    interlockState = ~interlockState;
    wait_valid("rst_start");
    outgoingTREADY = 1'b1;
    tick();
    tick();
    check("rst_word2", outgoingTDATA, word_of(interlockState, 2));
    outgoingTREADY = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", outgoingTVALID, 1'b0);
    tick();
    reset = 1'b0;
    outgoingTREADY = 1'b1;
    wait_valid("rst_restart");
    check("rst_restart_header", outgoingTDATA, 16'h2500);
    wait_pkts(1, 50, "rst_pkts");

    // Randomized traffic with occasional resets and reverting vectors.
    pool[0] = '0;
    pool[1] = 64'h1;
    pool[2] = '1;
    pool[3] = 64'h0123_4567_89AB_CDEF;
    rand_rdy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 19) == 0) interlockState = pool[$urandom_range(0, 3)];
      reset = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
